// File: rtl/rename_map_unit.sv
// Register rename unit: speculative RAT, retirement RAT and a circular physical free list.
// Latency: rename lookups are combinational; RAT/free-list updates are visible next cycle.
// Backpressure: rename_ready drops when the free list is empty or during a flush; commit never stalls.
module rename_map_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int AREG_W    = $clog2(ARCH_REGS),
  parameter int PREG_W    = $clog2(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rename_valid,
  output logic              rename_ready,
  input  logic [AREG_W-1:0] arch_src1,
  input  logic [AREG_W-1:0] arch_src2,
  input  logic [AREG_W-1:0] arch_dest,
  input  logic              dest_en,
  output logic [PREG_W-1:0] phys_src1,
  output logic [PREG_W-1:0] phys_src2,
  output logic [PREG_W-1:0] phys_dest,
  output logic [PREG_W-1:0] old_phys_dest,
  input  logic              commit_valid,
  input  logic              commit_dest_en,
  input  logic [AREG_W-1:0] commit_arch_dest,
  input  logic [PREG_W-1:0] commit_phys_dest,
  input  logic [PREG_W-1:0] commit_old_phys,
  input  logic              flush,
  output logic [PREG_W:0]   free_count
);

  // Registers not mapped by the architectural state at reset.
  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

  logic [PREG_W-1:0] r_spec_rat   [ARCH_REGS];
  logic [PREG_W-1:0] r_retire_rat [ARCH_REGS];
  logic [PREG_W-1:0] r_free_list  [PHYS_REGS];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PREG_W:0] r_head;
  logic [PREG_W:0] r_tail;
  logic [PREG_W:0] r_retire_head;

  logic              w_alloc;
  logic              w_fire;
  logic              w_alloc_fire;
  logic              w_commit_fire;
  logic [PREG_W:0]   w_free_count;
  logic [PREG_W-1:0] w_head_entry;

  assign w_free_count  = r_tail - r_head;
  // Ready ignores commits in the same cycle: a freed register is usable only next cycle.
  assign rename_ready  = !flush && (w_free_count != '0);
  assign w_fire        = rename_valid && rename_ready;
  // Architectural register 0 is hardwired and never gets a new mapping.
  assign w_alloc       = dest_en && (arch_dest != '0);
  assign w_alloc_fire  = w_fire && w_alloc;
  assign w_commit_fire = commit_valid && commit_dest_en && (commit_arch_dest != '0);
  assign w_head_entry  = r_free_list[r_head[PREG_W-1:0]];

  // Lookups read pre-update state, so src == dest sees the old mapping.
  assign phys_src1     = r_spec_rat[arch_src1];
  assign phys_src2     = r_spec_rat[arch_src2];
  assign old_phys_dest = r_spec_rat[arch_dest];
  assign phys_dest     = w_alloc ? w_head_entry : '0;
  assign free_count    = w_free_count;

  // Speculative and retirement RATs; a flush copies the retirement RAT including this cycle's commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_spec_rat[i]   <= PREG_W'(i);
        r_retire_rat[i] <= PREG_W'(i);
      end
    end else begin
      if (w_commit_fire) begin
        r_retire_rat[commit_arch_dest] <= commit_phys_dest;
      end
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          r_spec_rat[i] <= (w_commit_fire && (commit_arch_dest == AREG_W'(i)))
                           ? commit_phys_dest : r_retire_rat[i];
        end
      end else if (w_alloc_fire) begin
        r_spec_rat[arch_dest] <= w_head_entry;
      end
    end
  end

  // Free list: allocation pops at head, commit pushes the displaced register at tail.
  // retire_head tracks head as seen by committed instructions, so a flush rewinds head to it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        r_free_list[i] <= (i < FREE_INIT) ? PREG_W'(ARCH_REGS + i) : '0;
      end
      r_head        <= '0;
      r_retire_head <= '0;
      r_tail        <= (PREG_W+1)'(FREE_INIT);
    end else begin
      if (w_commit_fire) begin
        r_free_list[r_tail[PREG_W-1:0]] <= commit_old_phys;
        r_tail                          <= r_tail + 1'b1;
        r_retire_head                   <= r_retire_head + 1'b1;
      end
      if (flush) begin
        r_head <= w_commit_fire ? (r_retire_head + 1'b1) : r_retire_head;
      end else if (w_alloc_fire) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  // A commit can never push the free list beyond its capacity.
  a_free_list_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(w_commit_fire && !w_alloc_fire && !flush &&
      (w_free_count == (PREG_W+1)'(PHYS_REGS))));

endmodule

// File: tb/tb_rename_map_unit.sv
module tb_rename_map_unit;

  localparam int AREG_W = 5;
  localparam int PREG_W = 6;

  logic              clk;
  logic              reset;
  logic              rename_valid;
  logic              rename_ready;
  logic [AREG_W-1:0] arch_src1;
  logic [AREG_W-1:0] arch_src2;
  logic [AREG_W-1:0] arch_dest;
  logic              dest_en;
  logic [PREG_W-1:0] phys_src1;
  logic [PREG_W-1:0] phys_src2;
  logic [PREG_W-1:0] phys_dest;
  logic [PREG_W-1:0] old_phys_dest;
  logic              commit_valid;
  logic              commit_dest_en;
  logic [AREG_W-1:0] commit_arch_dest;
  logic [PREG_W-1:0] commit_phys_dest;
  logic [PREG_W-1:0] commit_old_phys;
  logic              flush;
  logic [PREG_W:0]   free_count;

  rename_map_unit #(.ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .rename_valid     (rename_valid),
    .rename_ready     (rename_ready),
    .arch_src1        (arch_src1),
    .arch_src2        (arch_src2),
    .arch_dest        (arch_dest),
    .dest_en          (dest_en),
    .phys_src1        (phys_src1),
    .phys_src2        (phys_src2),
    .phys_dest        (phys_dest),
    .old_phys_dest    (old_phys_dest),
    .commit_valid     (commit_valid),
    .commit_dest_en   (commit_dest_en),
    .commit_arch_dest (commit_arch_dest),
    .commit_phys_dest (commit_phys_dest),
    .commit_old_phys  (commit_old_phys),
    .flush            (flush),
    .free_count       (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected rename response; a negative field is not compared.
  typedef struct {
    int s1;
    int s2;
    int d;
    int od;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted rename pops one expectation and compares the lookup outputs.
  always @(negedge clk) begin
    if (reset && rename_valid && rename_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rename", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.s1 >= 0) chk("phys_src1", int'(phys_src1), e.s1);
        if (e.s2 >= 0) chk("phys_src2", int'(phys_src2), e.s2);
        if (e.d  >= 0) chk("phys_dest", int'(phys_dest), e.d);
        if (e.od >= 0) chk("old_phys_dest", int'(old_phys_dest), e.od);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drive_ren(input int a1, input int a2, input int ad, input bit den);
    arch_src1    = AREG_W'(a1);
    arch_src2    = AREG_W'(a2);
    arch_dest    = AREG_W'(ad);
    dest_en      = den;
    rename_valid = 1'b1;
  endtask

  // Waits (bounded) until the rename is accepted, then returns just after that edge.
  task automatic wait_fire;
    int n = 0;
    @(negedge clk);
    while (!rename_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rename_ready) chk("fire_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic rename_op(input int a1, input int a2, input int ad, input bit den,
                           input int e1, input int e2, input int ed, input int eod);
    exp_t e;
    e = '{e1, e2, ed, eod};
    exp_q.push_back(e);
    drive_ren(a1, a2, ad, den);
    wait_fire();
    rename_valid = 1'b0;
  endtask

  task automatic set_commit(input int ad, input int pd, input int od);
    commit_valid     = 1'b1;
    commit_dest_en   = 1'b1;
    commit_arch_dest = AREG_W'(ad);
    commit_phys_dest = PREG_W'(pd);
    commit_old_phys  = PREG_W'(od);
  endtask

  task automatic do_flush;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  int fl[$];
  int mrat[32];

  initial begin
    reset = 1'b0; rename_valid = 1'b0; arch_src1 = '0; arch_src2 = '0; arch_dest = '0;
    dest_en = 1'b0; commit_valid = 1'b0; commit_dest_en = 1'b0; commit_arch_dest = '0;
    commit_phys_dest = '0; commit_old_phys = '0; flush = 1'b0;

    // Test 1: reset state, first allocation, dependent read
    do_reset();
    chk("reset_free_count", int'(free_count), 32);
    chk("reset_ready", int'(rename_ready), 1);
    rename_op(2, 3, 1, 1, 2, 3, 32, 1);
    chk("t1_free_count", int'(free_count), 31);
    rename_op(1, 0, 0, 0, 32, 0, 0, 0);
    chk("t1_free_count_no_alloc", int'(free_count), 31);

    // Test 2: destination r0 is never renamed
    do_reset();
    rename_op(4, 5, 0, 1, 4, 5, 0, 0);
    chk("t2_free_count", int'(free_count), 32);
    rename_op(0, 1, 2, 1, 0, 1, 32, 2);

    // Test 3: exhaust the free list, commit does not bypass into the stalled rename
    do_reset();
    for (int i = 0; i < 32; i++) begin
      int ad;
      ad = 1 + (i % 31);
      rename_op(0, 0, ad, 1, 0, 0, 32 + i, (i < 31) ? ad : 32);
    end
    chk("t3_empty_count", int'(free_count), 0);
    chk("t3_empty_ready", int'(rename_ready), 0);
    drive_ren(0, 0, 2, 1);
    set_commit(1, 32, 5);
    #1 chk("t3_stall_ready", int'(rename_ready), 0);
    @(posedge clk);
    #1 commit_valid = 1'b0;
    #1 chk("t3_ready_after_commit", int'(rename_ready), 1);
    chk("t3_count_after_commit", int'(free_count), 1);
    rename_op(0, 0, 2, 1, 0, 0, 5, 33);
    chk("t3_count_final", int'(free_count), 0);

    // Test 4: flush with same-cycle commit restores precise state
    do_reset();
    rename_op(3, 0, 3, 1, 3, 0, 32, 3);
    rename_op(3, 3, 3, 1, 32, 32, 33, 32);
    set_commit(3, 32, 3);
    flush = 1'b1;
    #1 chk("t4_flush_ready", int'(rename_ready), 0);
    @(posedge clk);
    #1 flush = 1'b0;
    commit_valid = 1'b0;
    #1 chk("t4_free_count", int'(free_count), 32);
    rename_op(3, 0, 4, 1, 32, 0, 33, 4);

    // Test 5: 200 rename+commit pairs wrap the pointers
    do_reset();
    fl.delete();
    for (int i = 32; i < 64; i++) fl.push_back(i);
    for (int i = 0; i < 32; i++) mrat[i] = i;
    for (int i = 0; i < 200; i++) begin
      int ad;
      int ed;
      int od;
      ad = 1 + (i % 31);
      ed = fl.pop_front();
      od = mrat[ad];
      mrat[ad] = ed;
      fl.push_back(od);
      set_commit(ad, ed, od);
      rename_op(ad, 0, ad, 1, od, 0, ed, od);
      commit_valid = 1'b0;
      chk("t5_free_count", int'(free_count), 32);
    end

    // Test 6: reset overrides rename, commit and flush in the same cycle
    do_reset();
    rename_op(1, 2, 3, 1, 1, 2, 32, 3);
    rename_op(3, 0, 5, 1, 32, 0, 33, 5);
    drive_ren(3, 3, 7, 1);
    set_commit(3, 32, 3);
    flush = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    flush = 1'b0;
    commit_valid = 1'b0;
    rename_valid = 1'b0;
    #1 chk("t6_free_count", int'(free_count), 32);
    chk("t6_ready", int'(rename_ready), 1);
    rename_op(7, 3, 3, 1, 7, 3, 32, 3);
    do_flush();
    chk("t6_flush_count", int'(free_count), 32);
    for (int k = 0; k < 16; k++) begin
      rename_op(2 * k, 2 * k + 1, 0, 0, 2 * k, 2 * k + 1, 0, 0);
    end
    rename_op(0, 0, 9, 1, 0, 0, 32, 9);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
